// File: rtl/unidade_controle.sv
// Multicycle control unit for the MIPS-subset datapath: a Moore-style sequencer
// whose state code also drives the Estado debug port.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Overflow,
    input  logic       Igual,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWr,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       LoadA,
    output logic       LoadB,
    output logic       LoadAluOut,
    output logic       LoadMDR,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] AluOp,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic       ExcCause,
    output logic [6:0] Estado
);

    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH0   = 5'd1;
    localparam logic [4:0] S_FETCH1   = 5'd2;
    localparam logic [4:0] S_FETCH2   = 5'd3;
    localparam logic [4:0] S_DECODE   = 5'd4;
    localparam logic [4:0] S_R_EXEC   = 5'd5;
    localparam logic [4:0] S_R_WB     = 5'd6;
    localparam logic [4:0] S_I_EXEC   = 5'd7;
    localparam logic [4:0] S_I_WB     = 5'd8;
    localparam logic [4:0] S_LUI_WB   = 5'd9;
    localparam logic [4:0] S_MEM_ADDR = 5'd10;
    localparam logic [4:0] S_LW_RD0   = 5'd11;
    localparam logic [4:0] S_LW_RD1   = 5'd12;
    localparam logic [4:0] S_LW_MDR   = 5'd13;
    localparam logic [4:0] S_LW_WB    = 5'd14;
    localparam logic [4:0] S_SW       = 5'd15;
    localparam logic [4:0] S_BRANCH   = 5'd16;
    localparam logic [4:0] S_JUMP     = 5'd17;
    localparam logic [4:0] S_JR       = 5'd18;
    localparam logic [4:0] S_EXC      = 5'd19;
    localparam logic [4:0] S_HALT     = 5'd20;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_HALT = 6'h0D;

    logic [4:0] state_reg;
    logic [4:0] state_next;
    // Overflow flag doubles as the exception cause: it is cleared on the
    // bad-opcode path and stays set when an arithmetic overflow routes to EXC.
    logic       flag_reg;
    logic       flag_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_RESET;
            flag_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            flag_reg  <= flag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        flag_next  = flag_reg;
        case (state_reg)
            S_RESET:  state_next = S_FETCH0;
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
                flag_next = 1'b0;
                case (Opcode)
                    OP_RTYPE: begin
                        case (Funct)
                            FN_ADD, FN_SUB, FN_AND, FN_XOR: state_next = S_R_EXEC;
                            FN_JR:                          state_next = S_JR;
                            FN_HALT:                        state_next = S_HALT;
                            default:                        state_next = S_EXC;
                        endcase
                    end
                    OP_ADDI:       state_next = S_I_EXEC;
                    OP_LUI:        state_next = S_LUI_WB;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_EXC;
                endcase
            end
            S_R_EXEC: begin
                flag_next  = ((Funct == FN_ADD) || (Funct == FN_SUB)) ? Overflow : 1'b0;
                state_next = S_R_WB;
            end
            S_R_WB, S_I_WB: state_next = flag_reg ? S_EXC : S_FETCH0;
            S_I_EXEC: begin
                flag_next  = Overflow;
                state_next = S_I_WB;
            end
            S_LUI_WB:   state_next = S_FETCH0;
            S_MEM_ADDR: state_next = (Opcode == OP_LW) ? S_LW_RD0 : S_SW;
            S_LW_RD0:   state_next = S_LW_RD1;
            S_LW_RD1:   state_next = S_LW_MDR;
            S_LW_MDR:   state_next = S_LW_WB;
            S_LW_WB, S_SW, S_BRANCH, S_JUMP, S_JR: state_next = S_FETCH0;
            S_EXC: begin
                flag_next  = 1'b0;
                state_next = S_FETCH0;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemWr      = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        LoadA      = 1'b0;
        LoadB      = 1'b0;
        LoadAluOut = 1'b0;
        LoadMDR    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        AluOp      = 3'b000;
        PCSource   = 2'b00;
        EPCWrite   = 1'b0;
        ExcCause   = 1'b0;
        case (state_reg)
            S_FETCH0: begin
                ALUSrcB    = 2'b01;
                AluOp      = 3'b001;
                LoadAluOut = 1'b1;
            end
            S_FETCH2: begin
                IRWrite  = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b01;
            end
            S_DECODE: begin
                LoadA      = 1'b1;
                LoadB      = 1'b1;
                ALUSrcB    = 2'b11;
                AluOp      = 3'b001;
                LoadAluOut = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA    = 1'b1;
                LoadAluOut = 1'b1;
                case (Funct)
                    FN_SUB:  AluOp = 3'b010;
                    FN_AND:  AluOp = 3'b011;
                    FN_XOR:  AluOp = 3'b110;
                    default: AluOp = 3'b001;
                endcase
            end
            S_R_WB: begin
                RegWrite = ~flag_reg;
                RegDst   = flag_reg ? 2'b00 : 2'b01;
            end
            S_I_EXEC, S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                AluOp      = 3'b001;
                LoadAluOut = 1'b1;
            end
            S_I_WB:   RegWrite = ~flag_reg;
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
            end
            S_LW_RD0, S_LW_RD1: IorD = 1'b1;
            S_LW_MDR: begin
                IorD    = 1'b1;
                LoadMDR = 1'b1;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_SW: begin
                IorD  = 1'b1;
                MemWr = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                AluOp    = 3'b111;
                PCSource = 2'b01;
                PCWrite  = (Opcode == OP_BEQ) ? Igual : ~Igual;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JR: begin
                ALUSrcA = 1'b1;
                PCWrite = 1'b1;
            end
            // PC already points past the faulting instruction; PC-4 goes to EPC.
            S_EXC: begin
                ALUSrcB  = 2'b01;
                AluOp    = 3'b010;
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                ExcCause = flag_reg;
            end
            default: ;
        endcase
    end

    assign Estado = {2'b00, state_reg};

endmodule
